// File: rtl/cache_pkg.sv
// Package cache_pkg
// Shared defaults, derived-size helpers and flush FSM encodings for the
// set-associative tag store (cache_tag_array and cache_tag_way).
package cache_pkg;

    localparam int TAG_W_DEF   = 14;
    localparam int INDEX_W_DEF = 4;
    localparam int WAYS_DEF    = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    // Way-select width; a direct-mapped store still needs a 1-bit way field.
    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int num_sets(input int index_w);
        return 1 << index_w;
    endfunction

endpackage

// File: rtl/cache_tag_way.sv
// Module cache_tag_way
// One way of the tag store: per-set tag + valid bit (+ even-parity bit when
// CACHE_TAG_PARITY_EN is defined), with three independent compare ports.
// Ports:
//   clk, rst                     clock / asynchronous active-low reset
//   lk_index, lk_tag -> lk_match valid & tag equal (& parity good)
//   lk_par_bad                   valid entry at lk_index has bad parity (parity build only)
//   fill_index, fill_tag         fill_match (valid & equal), fill_valid (entry valid)
//   inv_index, inv_tag           inv_match (valid & equal)
//   wr_en                        write fill_tag into fill_index, set valid
//   clr_en, clr_index            clear valid at clr_index (invalidate or flush)
module cache_tag_way import cache_pkg::*; #(
    parameter int TAG_W   = TAG_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] lk_index,
    input  logic [TAG_W-1:0]   lk_tag,
    output logic               lk_match,
`ifdef CACHE_TAG_PARITY_EN
    output logic               lk_par_bad,
`endif
    input  logic [INDEX_W-1:0] fill_index,
    input  logic [TAG_W-1:0]   fill_tag,
    output logic               fill_match,
    output logic               fill_valid,
    input  logic [INDEX_W-1:0] inv_index,
    input  logic [TAG_W-1:0]   inv_tag,
    output logic               inv_match,
    input  logic               wr_en,
    input  logic               clr_en,
    input  logic [INDEX_W-1:0] clr_index
);

    localparam int SETS = num_sets(INDEX_W);

    logic [TAG_W-1:0] tag_mem [SETS];
    logic [SETS-1:0]  valid;

    // NOTE: this array is built from flops, not an SRAM macro, so it can be
    // reset; tags are cleared along with valid bits so post-reset state is fully defined.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int s = 0; s < SETS; s++) tag_mem[s] <= '0;
        end else if (wr_en) begin
            valid[fill_index]   <= 1'b1;
            tag_mem[fill_index] <= fill_tag;
        end else if (clr_en) begin
            valid[clr_index] <= 1'b0;
        end
    end

`ifdef CACHE_TAG_PARITY_EN
    logic [SETS-1:0] par_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       par_mem <= '0;
        else if (wr_en) par_mem[fill_index] <= ^fill_tag;
    end

    // A corrupted entry must never report a hit, even if its tag happens to match.
    assign lk_par_bad = valid[lk_index] & (par_mem[lk_index] != ^tag_mem[lk_index]);
    assign lk_match   = valid[lk_index] & (tag_mem[lk_index] == lk_tag) & ~lk_par_bad;
`else
    assign lk_match   = valid[lk_index] & (tag_mem[lk_index] == lk_tag);
`endif

    assign fill_valid = valid[fill_index];
    assign fill_match = valid[fill_index] & (tag_mem[fill_index] == fill_tag);
    assign inv_match  = valid[inv_index] & (tag_mem[inv_index] == inv_tag);

endmodule

// File: rtl/cache_tag_array.sv
// Module cache_tag_array
// N-way set-associative tag store: registered lookup, victim selection on
// fill (lowest invalid way, else per-set round-robin), single-line invalidate
// and a one-set-per-cycle flush walk.
// Optional feature macro: CACHE_TAG_PARITY_EN (per-tag even parity, par_err).
// Ports:
//   clk, rst                          clock / asynchronous active-low reset
//   lk_en, lk_index, lk_tag           lookup request
//   hit, hit_way, lk_done             registered lookup result
//   fill_en, fill_index, fill_tag     fill request; fill_way = chosen way (comb)
//   inv_en, inv_index, inv_tag        invalidate one line
//   flush_req, busy, flush_done       invalidate-all walk
//   par_err                           registered parity error (0 without parity)
module cache_tag_array import cache_pkg::*; #(
    parameter int TAG_W   = TAG_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int WAYS    = WAYS_DEF,
    parameter int WAY_W   = way_width(WAYS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lk_en,
    input  logic [INDEX_W-1:0] lk_index,
    input  logic [TAG_W-1:0]   lk_tag,
    output logic               hit,
    output logic [WAY_W-1:0]   hit_way,
    output logic               lk_done,
    input  logic               fill_en,
    input  logic [INDEX_W-1:0] fill_index,
    input  logic [TAG_W-1:0]   fill_tag,
    output logic [WAY_W-1:0]   fill_way,
    input  logic               inv_en,
    input  logic [INDEX_W-1:0] inv_index,
    input  logic [TAG_W-1:0]   inv_tag,
    input  logic               flush_req,
    output logic               busy,
    output logic               flush_done,
    output logic               par_err
);

    localparam int SETS = num_sets(INDEX_W);

    flush_state_e       state, next_state;
    logic [INDEX_W-1:0] flush_cnt;
    logic [WAY_W-1:0]   rr_ptr [SETS];

    logic [WAYS-1:0] lk_match_vec, fill_match_vec, fill_valid_vec, inv_match_vec;
    logic [WAYS-1:0] wr_en_vec, clr_en_vec;
    logic            fill_ok, inv_ok, use_rr, lk_hit;
    logic [INDEX_W-1:0] clr_index;
    logic [WAY_W-1:0]   lk_way;
`ifdef CACHE_TAG_PARITY_EN
    logic [WAYS-1:0] lk_par_bad_vec;
`endif

    assign busy      = (state == ST_FLUSH);
    assign fill_ok   = fill_en & ~busy;
    assign inv_ok    = inv_en & ~fill_en & ~busy;
    assign clr_index = busy ? flush_cnt : inv_index;
    assign lk_hit    = lk_en & ~busy & (|lk_match_vec);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign wr_en_vec[w]  = fill_ok & (fill_way == WAY_W'(w));
        // The flush walk clears every way of the current set at once.
        assign clr_en_vec[w] = busy | (inv_ok & inv_match_vec[w]);

        cache_tag_way #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) u_way (
            .clk        (clk),
            .rst        (rst),
            .lk_index   (lk_index),
            .lk_tag     (lk_tag),
            .lk_match   (lk_match_vec[w]),
`ifdef CACHE_TAG_PARITY_EN
            .lk_par_bad (lk_par_bad_vec[w]),
`endif
            .fill_index (fill_index),
            .fill_tag   (fill_tag),
            .fill_match (fill_match_vec[w]),
            .fill_valid (fill_valid_vec[w]),
            .inv_index  (inv_index),
            .inv_tag    (inv_tag),
            .inv_match  (inv_match_vec[w]),
            .wr_en      (wr_en_vec[w]),
            .clr_en     (clr_en_vec[w]),
            .clr_index  (clr_index)
        );
    end

    // Victim: rewrite an existing copy of the tag, else lowest invalid way,
    // else round-robin. Only the round-robin case advances the pointer.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        fill_way = rr_ptr[fill_index];
        use_rr   = 1'b1;
        if (|fill_match_vec) begin
            use_rr = 1'b0;
            for (int w = 0; w < WAYS; w++)
                if (fill_match_vec[w]) fill_way = WAY_W'(w);
        end else if (!(&fill_valid_vec)) begin
            use_rr = 1'b0;
            for (int w = WAYS - 1; w >= 0; w--)
                if (!fill_valid_vec[w]) fill_way = WAY_W'(w);
        end
    end

    // Matches are one-hot (fills never duplicate a tag), so a plain encoder suffices.
    always_comb begin
        lk_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (lk_match_vec[w]) lk_way = WAY_W'(w);
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (flush_req) next_state = ST_FLUSH;
            ST_FLUSH: if (&flush_cnt) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            flush_cnt  <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= next_state;
            flush_cnt  <= busy ? flush_cnt + 1'b1 : '0;
            flush_done <= busy & (&flush_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else if (busy) begin
            rr_ptr[flush_cnt] <= '0;
        end else if (fill_ok && use_rr) begin
            rr_ptr[fill_index] <= (rr_ptr[fill_index] == WAY_W'(WAYS - 1)) ? '0
                                                                          : rr_ptr[fill_index] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lk_done <= 1'b0;
            hit     <= 1'b0;
            hit_way <= '0;
        end else begin
            lk_done <= lk_en;
            hit     <= lk_hit;
            hit_way <= lk_hit ? lk_way : '0;
        end
    end

`ifdef CACHE_TAG_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_err <= 1'b0;
        else      par_err <= lk_en & ~busy & (|lk_par_bad_vec);
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_tag_array.sv
// Testbench for cache_tag_array (default parameters: TAG_W=14, INDEX_W=4, WAYS=2).
// Inputs are driven on the falling edge; registered outputs are compared on the
// following falling edge against a set/way reference model kept in arrays.
// The parity scenario is compiled only when CACHE_TAG_PARITY_EN is defined.
module tb_cache_tag_array;

    localparam int TAG_W   = 14;
    localparam int INDEX_W = 4;
    localparam int WAYS    = 2;
    localparam int WAY_W   = 1;
    localparam int SETS    = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               lk_en, fill_en, inv_en, flush_req;
    logic [INDEX_W-1:0] lk_index, fill_index, inv_index;
    logic [TAG_W-1:0]   lk_tag, fill_tag, inv_tag;
    logic               hit, lk_done, busy, flush_done, par_err;
    logic [WAY_W-1:0]   hit_way, fill_way;

    cache_tag_array #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst),
        .lk_en(lk_en), .lk_index(lk_index), .lk_tag(lk_tag),
        .hit(hit), .hit_way(hit_way), .lk_done(lk_done),
        .fill_en(fill_en), .fill_index(fill_index), .fill_tag(fill_tag), .fill_way(fill_way),
        .inv_en(inv_en), .inv_index(inv_index), .inv_tag(inv_tag),
        .flush_req(flush_req), .busy(busy), .flush_done(flush_done), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what each set holds, plus the flush walk position.
    bit         m_valid [SETS][WAYS];
    bit [13:0]  m_tag   [SETS][WAYS];
    bit         m_pbad  [SETS][WAYS];
    int         m_rr    [SETS];
    bit         m_flushing;
    int         m_fpos;
    bit         e_hit, e_done, e_fdone, e_perr;
    int         e_hw;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0; m_tag[s][w] = '0; m_pbad[s][w] = 0;
            end
        end
        m_flushing = 0; m_fpos = 0;
    endtask

    // Which way a fill goes to, and whether that choice consumes the round-robin pointer.
    task automatic model_victim(input int idx, input bit [13:0] t, output int way, output bit rr_used);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == t) begin way = w; rr_used = 0; return; end
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[idx][w]) begin way = w; rr_used = 0; return; end
        way = m_rr[idx]; rr_used = 1;
    endtask

    // One clock: drive at the falling edge, check fill_way, apply the edge, check registered outputs.
    task automatic step(input bit le, input int li, input bit [13:0] lt,
                        input bit fe, input int fi, input bit [13:0] ft,
                        input bit ie, input int ii, input bit [13:0] it,
                        input bit fr);
        int  vw;
        bit  rr_used;
        lk_en = le; lk_index = 4'(li); lk_tag = lt;
        fill_en = fe; fill_index = 4'(fi); fill_tag = ft;
        inv_en = ie; inv_index = 4'(ii); inv_tag = it;
        flush_req = fr;
        #1;
        model_victim(fi, ft, vw, rr_used);
        if (fe && !m_flushing) check("fill_way", 32'(fill_way), 32'(vw));

        // Lookup sees the contents before this edge.
        e_done = le; e_hit = 0; e_hw = 0; e_perr = 0;
        if (le && !m_flushing)
            for (int w = 0; w < WAYS; w++) begin
                if (m_valid[li][w] && m_pbad[li][w]) e_perr = 1;
                else if (m_valid[li][w] && m_tag[li][w] == lt) begin e_hit = 1; e_hw = w; end
            end
`ifndef CACHE_TAG_PARITY_EN
        e_perr = 0;
`endif
        e_fdone = 0;
        if (m_flushing) begin
            for (int w = 0; w < WAYS; w++) m_valid[m_fpos][w] = 0;
            m_rr[m_fpos] = 0;
            if (m_fpos == SETS - 1) begin m_flushing = 0; e_fdone = 1; end
            else m_fpos++;
        end else begin
            if (fe) begin
                m_valid[fi][vw] = 1; m_tag[fi][vw] = ft; m_pbad[fi][vw] = 0;
                if (rr_used) m_rr[fi] = (m_rr[fi] + 1) % WAYS;
            end else if (ie) begin
                for (int w = 0; w < WAYS; w++)
                    if (m_valid[ii][w] && m_tag[ii][w] == it) m_valid[ii][w] = 0;
            end
            if (fr) begin m_flushing = 1; m_fpos = 0; end
        end

        @(posedge clk);
        @(negedge clk);
        check("lk_done",    32'(lk_done),    32'(e_done));
        check("hit",        32'(hit),        32'(e_hit));
        check("hit_way",    32'(hit_way),    32'(e_hw));
        check("busy",       32'(busy),       32'(m_flushing));
        check("flush_done", 32'(flush_done), 32'(e_fdone));
        check("par_err",    32'(par_err),    32'(e_perr));
    endtask

    task automatic idle();                       step(0,0,0, 0,0,0, 0,0,0, 0); endtask
    task automatic do_lookup(input int i, input bit [13:0] t); step(1,i,t, 0,0,0, 0,0,0, 0); endtask
    task automatic do_fill(input int i, input bit [13:0] t);   step(0,0,0, 1,i,t, 0,0,0, 0); endtask
    task automatic do_inv(input int i, input bit [13:0] t);    step(0,0,0, 0,0,0, 1,i,t, 0); endtask
    task automatic do_flush();                   step(0,0,0, 0,0,0, 0,0,0, 1); endtask

    initial begin
        int busy_cycles;
        rst = 1'b0;
        lk_en = 0; fill_en = 0; inv_en = 0; flush_req = 0;
        lk_index = '0; fill_index = '0; inv_index = '0;
        lk_tag = '0; fill_tag = '0; inv_tag = '0;
        model_reset();
        #2;
        check("rst_hit",     32'(hit), 0);
        check("rst_hit_way", 32'(hit_way), 0);
        check("rst_lk_done", 32'(lk_done), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_fdone",   32'(flush_done), 0);
        check("rst_par_err", 32'(par_err), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // 1: lookup on empty store
        do_lookup(3, 14'h155);
        check("t1_done", 32'(lk_done), 1);
        check("t1_hit",  32'(hit), 0);

        // 2: two fills to set 5 take ways 0 then 1
        do_fill(5, 14'h0AA);
        do_fill(5, 14'h0BB);
        do_lookup(5, 14'h0BB);
        check("t2_hit",     32'(hit), 1);
        check("t2_hit_way", 32'(hit_way), 1);

        // 3: full set, round-robin replacement
        do_fill(5, 14'h0CC);
        do_fill(5, 14'h0DD);
        do_lookup(5, 14'h0AA);
        check("t3_miss", 32'(hit), 0);
        do_lookup(5, 14'h0DD);

        // 4: duplicate fill rewrites in place
        do_fill(2, 14'h011);
        do_fill(2, 14'h011);
        do_fill(2, 14'h022);

        // Invalidate hit / miss, fill+inv same cycle, lookup concurrent with fill
        do_inv(5, 14'h0CC);
        do_inv(5, 14'h0EE);
        do_lookup(5, 14'h0CC);
        step(1,5,14'h0DD, 1,5,14'h0FF, 1,5,14'h0DD, 0);
        do_lookup(5, 14'h0DD);

        // 5: flush with populated sets
        for (int s = 0; s < SETS; s += 3) do_fill(s, 14'(s + 14'h100));
        do_flush();
        busy_cycles = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            busy_cycles++;
            step(1, k % SETS, 14'h100, 1, 0, 14'h3, 0,0,0, 1);
        end
        check("t5_busy_len", 32'(busy_cycles), 16);
        for (int s = 0; s < SETS; s += 3) do_lookup(s, 14'(s + 14'h100));

        // 6: reset in the middle of a flush
        do_fill(7, 14'h077);
        do_flush();
        repeat (6) idle();
        rst = 1'b0;
        #1;
        check("t6_busy",  32'(busy), 0);
        check("t6_fdone", 32'(flush_done), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        check("t6_fdone_after", 32'(flush_done), 0);
        do_lookup(7, 14'h077);
        do_lookup(0, 14'h0);

`ifdef CACHE_TAG_PARITY_EN
        // 7: corrupt parity of set 1 way 0
        do_fill(1, 14'h123);
        dut.g_way[0].u_way.par_mem[1] = ~dut.g_way[0].u_way.par_mem[1];
        m_pbad[1][0] = 1;
        do_lookup(1, 14'h123);
        check("t7_hit",  32'(hit), 0);
        check("t7_perr", 32'(par_err), 1);
        idle();
        do_fill(1, 14'h123);
        do_lookup(1, 14'h123);
`endif

        // Randomised traffic over a few sets and tags to force collisions and replacement
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3), 14'(14'h200 + $urandom_range(0, 5)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3), 14'(14'h200 + $urandom_range(0, 5)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3), 14'(14'h200 + $urandom_range(0, 5)),
                 $urandom_range(0, 59) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
